// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// default sizing and the requester-index width helper.
package mult_arb_pkg;

   localparam int unsigned DEF_WIDTH   = 32;
   localparam int unsigned DEF_NREQ    = 4;
   localparam int unsigned DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   // A single requester still needs a 1-bit index field.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_arb.sv
// Combinational round-robin picker: first set request after the last grant,
// wrapping, reported both one-hot and as an index.
module rr_arb
   import mult_arb_pkg::*;
#(
   parameter int unsigned NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]           i_req,
   input  logic [id_w(NREQ)-1:0]     i_last,
   output logic [NREQ-1:0]           o_gnt_oh,
   output logic [id_w(NREQ)-1:0]     o_gnt_idx,
   output logic                      o_any
);

   localparam int unsigned ID_W = id_w(NREQ);

   always_comb begin
      int unsigned v_idx;
      logic        v_found;
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      v_found   = 1'b0;
      v_idx     = 0;
      // Offsets 1..NREQ visit every slot once, ending on the last grant itself.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         v_idx = (int'(i_last) + k) % NREQ;
         if (!v_found && i_req[v_idx]) begin
            v_found          = 1'b1;
            o_gnt_oh[v_idx]  = 1'b1;
            o_gnt_idx        = ID_W'(v_idx);
         end
      end
      o_any = v_found;
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier between NREQ requesters: round-robin grant,
// enable/done sequencing, tagged responses and a watchdog abort.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned NREQ    = DEF_NREQ,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic                    rsp_valid,
   output logic [id_w(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic [WIDTH-1:0]        mult_a,
   output logic [WIDTH-1:0]        mult_b,
   output logic                    mult_enable,
   input  logic                    mult_done,
   input  logic [WIDTH-1:0]        mult_result
);

   localparam int unsigned ID_W = id_w(NREQ);
   localparam int unsigned WD_W = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;

   logic [1:0]       r_state;
   logic [ID_W-1:0]  r_last;
   logic [ID_W-1:0]  r_id;
   logic [WD_W-1:0]  r_wd;
   logic             r_en;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_rsp_valid;
   logic             r_rsp_err;
   logic [WIDTH-1:0] r_rsp_data;
   logic [ID_W-1:0]  r_rsp_id;

   logic [NREQ-1:0]  w_gnt_oh;
   logic [ID_W-1:0]  w_gnt_idx;
   logic             w_any;

   rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .i_req     (req_valid),
      .i_last    (r_last),
      .o_gnt_oh  (w_gnt_oh),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   // Gated by rst so no accept pulse can appear while reset is held.
   assign req_ready   = (rst && r_state == S_IDLE) ? w_gnt_oh : '0;
   assign busy        = (r_state != S_IDLE);
   assign mult_a      = r_a;
   assign mult_b      = r_b;
   assign mult_enable = r_en;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_err     = r_rsp_err;
   assign rsp_data    = r_rsp_data;
   assign rsp_id      = r_rsp_id;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_last      <= ID_W'(NREQ - 1);
         r_id        <= '0;
         r_wd        <= '0;
         r_en        <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_id    <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_a     <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
                  r_b     <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
                  r_id    <= w_gnt_idx;
                  r_last  <= w_gnt_idx;
                  r_wd    <= '0;
                  r_en    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // Done is tested first so it wins over a simultaneous timeout.
               if (mult_done) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= mult_result;
                  r_rsp_id    <= r_id;
                  r_en        <= 1'b0;
                  r_state     <= S_DRAIN;
               end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_id    <= r_id;
                  r_en        <= 1'b0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_wd <= r_wd + 1'b1;
               end
            end
            S_DRAIN: begin
               if (!mult_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural iterative multiplier
// whose latency and post-enable done hold are set per scenario.
module tb_mult_arbiter;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned NREQ    = 4;
   localparam int unsigned TIMEOUT = 64;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic [WIDTH-1:0]      mult_a;
   logic [WIDTH-1:0]      mult_b;
   logic                  mult_enable;
   logic                  mult_done = 1'b0;
   logic [WIDTH-1:0]      mult_result = '0;

   mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .busy        (busy),
      .mult_a      (mult_a),
      .mult_b      (mult_b),
      .mult_enable (mult_enable),
      .mult_done   (mult_done),
      .mult_result (mult_result)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        err;
      logic [31:0] a;
      logic [31:0] b;
      int          en;
   } rsp_t;

   typedef struct {
      logic [NREQ-1:0] oh;
      int              gap;
   } gnt_t;

   rsp_t q_rsp[$];
   gnt_t q_gnt[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_gnt   = 0;
   int n_rsp   = 0;
   int cyc     = 0;
   int rsp_cyc = 0;
   int en_cnt  = 0;
   int lat     = 0;
   int hold    = 0;
   int m_cnt   = 0;
   int m_hc    = 0;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Multiplier model: done rises after `lat` enabled edges (never if 0),
   // then lingers `hold` edges after enable drops.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt     <= 0;
         m_hc      <= 0;
         mult_done <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (mult_enable) begin
            m_cnt       <= m_cnt + 1;
            m_hc        <= hold;
            mult_result <= mult_a * mult_b;
            if (lat != 0 && m_cnt + 1 == lat) mult_done <= 1'b1;
         end else begin
            m_cnt <= 0;
            if (mult_done && m_hc != 0) m_hc <= m_hc - 1;
            else mult_done <= 1'b0;
         end
      end
   end

   always @(negedge clk or negedge rst) begin
      gnt_t g;
      rsp_t r;
      #1;
      if (!rst) begin
         en_cnt = 0;
         check("rst_req_ready",   64'(req_ready),   64'd0);
         check("rst_rsp_valid",   64'(rsp_valid),   64'd0);
         check("rst_rsp_err",     64'(rsp_err),     64'd0);
         check("rst_rsp_data",    64'(rsp_data),    64'd0);
         check("rst_rsp_id",      64'(rsp_id),      64'd0);
         check("rst_busy",        64'(busy),        64'd0);
         check("rst_mult_enable", 64'(mult_enable), 64'd0);
         check("rst_mult_a",      64'(mult_a),      64'd0);
         check("rst_mult_b",      64'(mult_b),      64'd0);
      end else begin
         if (mult_enable) begin
            en_cnt++;
            check("busy_in_run", 64'(busy), 64'd1);
         end
         if (req_ready != '0) begin
            n_gnt++;
            if (q_gnt.size() == 0) begin
               check("unexpected_grant", 64'(req_ready), 64'd0);
            end else begin
               g = q_gnt.pop_front();
               check("grant_onehot", 64'(req_ready), 64'(g.oh));
               if (g.gap >= 0) check("grant_gap", 64'(cyc - rsp_cyc), 64'(g.gap));
            end
         end
         if (rsp_valid) begin
            n_rsp++;
            if (q_rsp.size() == 0) begin
               check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               r = q_rsp.pop_front();
               check("rsp_id",     64'(rsp_id),      64'(r.id));
               check("rsp_data",   64'(rsp_data),    64'(r.data));
               check("rsp_err",    64'(rsp_err),     64'(r.err));
               check("en_cycles",  64'(en_cnt),      64'(r.en));
               check("en_low_rsp", 64'(mult_enable), 64'd0);
               check("hold_a",     64'(mult_a),      64'(r.a));
               check("hold_b",     64'(mult_b),      64'(r.b));
            end
            en_cnt  = 0;
            rsp_cyc = cyc;
         end
      end
   end

   task automatic wait_gnt(input int target);
      int k = 0;
      while (n_gnt < target && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (n_gnt < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL grant_timeout: got %0d grants expected %0d", n_gnt, target);
      end
   endtask

   task automatic wait_rsp(input int target);
      int k = 0;
      while (n_rsp < target && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (n_rsp < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL rsp_timeout: got %0d responses expected %0d", n_rsp, target);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic run_op(input logic [NREQ-1:0] mask, input int id, input logic [31:0] a,
                         input logic [31:0] b, input int lat_i, input logic err,
                         input logic [31:0] data, input int en);
      rsp_t r;
      gnt_t g;
      int   tg;
      int   tr;
      lat = lat_i;
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
      g.oh = '0;
      g.oh[id] = 1'b1;
      g.gap = -1;
      q_gnt.push_back(g);
      r = '{id, data, err, a, b, en};
      q_rsp.push_back(r);
      tg = n_gnt + 1;
      tr = n_rsp + 1;
      req_valid = mask;
      wait_gnt(tg);
      req_valid = '0;
      wait_rsp(tr);
   endtask

   initial begin
      rsp_t r;
      gnt_t g;
      int   tg;
      int   tr;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Single request, 7*6 with latency 35.
      run_op(4'b0001, 0, 32'd7, 32'd6, 35, 1'b0, 32'd42, 36);

      // Round robin from reset: 0,1,2,3,0.
      do_reset();
      lat = 3;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = 32'(i + 1);
         req_b[i*WIDTH +: WIDTH] = 32'd3;
      end
      g = '{4'b0001, -1}; q_gnt.push_back(g);
      g = '{4'b0010,  2}; q_gnt.push_back(g);
      g = '{4'b0100,  2}; q_gnt.push_back(g);
      g = '{4'b1000,  2}; q_gnt.push_back(g);
      g = '{4'b0001,  2}; q_gnt.push_back(g);
      r = '{0, 32'd3,  1'b0, 32'd1, 32'd3, 4}; q_rsp.push_back(r);
      r = '{1, 32'd6,  1'b0, 32'd2, 32'd3, 4}; q_rsp.push_back(r);
      r = '{2, 32'd9,  1'b0, 32'd3, 32'd3, 4}; q_rsp.push_back(r);
      r = '{3, 32'd12, 1'b0, 32'd4, 32'd3, 4}; q_rsp.push_back(r);
      r = '{0, 32'd3,  1'b0, 32'd1, 32'd3, 4}; q_rsp.push_back(r);
      tg = n_gnt + 5;
      tr = n_rsp + 5;
      req_valid = 4'b1111;
      wait_gnt(tg);
      req_valid = '0;
      wait_rsp(tr);

      // Wrap and skip, plus truncation of a wide product.
      run_op(4'b0100, 2, 32'd5, 32'd9, 4, 1'b0, 32'd45, 5);
      run_op(4'b0010, 1, 32'd100, 32'd200, 4, 1'b0, 32'd20000, 5);
      run_op(4'b1001, 3, 32'hFFFF_FFFF, 32'd2, 4, 1'b0, 32'hFFFF_FFFE, 5);

      // Done lingers 3 cycles after enable drops: next grant 5 cycles after rsp.
      hold = 3;
      lat  = 5;
      req_a[0*WIDTH +: WIDTH] = 32'd4; req_b[0*WIDTH +: WIDTH] = 32'd5;
      req_a[1*WIDTH +: WIDTH] = 32'd6; req_b[1*WIDTH +: WIDTH] = 32'd7;
      g = '{4'b0001, -1}; q_gnt.push_back(g);
      g = '{4'b0010,  5}; q_gnt.push_back(g);
      r = '{0, 32'd20, 1'b0, 32'd4, 32'd5, 6}; q_rsp.push_back(r);
      r = '{1, 32'd42, 1'b0, 32'd6, 32'd7, 6}; q_rsp.push_back(r);
      tg = n_gnt + 2;
      tr = n_rsp + 2;
      req_valid = 4'b0011;
      wait_gnt(tg);
      req_valid = '0;
      wait_rsp(tr);
      hold = 0;

      // Watchdog: done never comes.
      run_op(4'b0100, 2, 32'd11, 32'd13, 0, 1'b1, 32'd0, 64);

      // Done arrives exactly when the watchdog would fire.
      run_op(4'b1000, 3, 32'd1234, 32'd3, 63, 1'b0, 32'd3702, 64);

      // Asynchronous reset in the middle of RUN.
      lat = 50;
      req_a[3*WIDTH +: WIDTH] = 32'd77;
      req_b[3*WIDTH +: WIDTH] = 32'd2;
      g = '{4'b1000, -1}; q_gnt.push_back(g);
      r = '{3, 32'd154, 1'b0, 32'd77, 32'd2, 51}; q_rsp.push_back(r);
      tg = n_gnt + 1;
      req_valid = 4'b1000;
      wait_gnt(tg);
      req_valid = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      r = q_rsp.pop_back();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      run_op(4'b1111, 0, 32'd9, 32'd9, 2, 1'b0, 32'd81, 3);

      repeat (5) @(posedge clk);
      #1;
      check("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
      check("rsp_queue_empty", 64'(q_rsp.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
